// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes host words MSB-first into ccff_head,
// optionally recirculates the chain once and compares CRC-16/CCITT of loaded vs read-back bits.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_fail,
    output logic [15:0]       crc_out
);
    localparam int          BW       = $clog2(WORD_W + 1);
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [15:0]       crc_load_q, crc_load_d;
    logic [15:0]       crc_rb_q, crc_rb_d;
    logic [15:0]       crc_out_q, crc_out_d;
    logic              verify_q, verify_d;
    logic              done_q, done_d;
    logic              verify_fail_q, verify_fail_d;

    logic [31:0] bits_left_w, buf_cnt_w, remain_w;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    assign bits_left_w = 32'(bits_left_q);
    assign buf_cnt_w   = 32'(buf_cnt_q);

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        buf_cnt_d     = buf_cnt_q;
        bits_left_d   = bits_left_q;
        crc_load_d    = crc_load_q;
        crc_rb_d      = crc_rb_q;
        crc_out_d     = crc_out_q;
        verify_d      = verify_q;
        done_d        = done_q;
        verify_fail_d = verify_fail_q;
        data_ready    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        remain_w      = bits_left_w;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    done_d        = 1'b0;
                    verify_fail_d = 1'b0;
                    bits_left_d   = CNT_W'(CHAIN_LEN);
                    buf_cnt_d     = '0;
                    crc_load_d    = CRC_INIT;
                    crc_rb_d      = CRC_INIT;
                    verify_d      = verify_en;
                end
            end
            S_LOAD: begin
                // Refill while the last buffered bit goes out, so words stream without a bubble.
                data_ready = (buf_cnt_w <= 32'd1) && (bits_left_w > buf_cnt_w);
                if (buf_cnt_q != '0) begin
                    ccff_shift_en = 1'b1;
                    ccff_head     = buf_q[WORD_W-1];
                    buf_d         = buf_q << 1;
                    buf_cnt_d     = buf_cnt_q - BW'(1);
                    bits_left_d   = bits_left_q - CNT_W'(1);
                    remain_w      = bits_left_w - 32'd1;
                    crc_load_d    = crc_step(crc_load_q, buf_q[WORD_W-1]);
                    if (bits_left_w == 32'd1) begin
                        if (verify_q) begin
                            state_d     = S_VERIFY;
                            bits_left_d = CNT_W'(CHAIN_LEN);
                        end else begin
                            state_d       = S_DONE;
                            done_d        = 1'b1;
                            crc_out_d     = crc_load_d;
                            verify_fail_d = 1'b0;
                        end
                    end
                end
                if (data_ready && data_valid) begin
                    buf_d     = data_in;
                    // A short final word keeps only the bits the chain still needs.
                    buf_cnt_d = (remain_w > 32'(WORD_W)) ? BW'(WORD_W) : BW'(remain_w);
                end
            end
            S_VERIFY: begin
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                crc_rb_d      = crc_step(crc_rb_q, ccff_tail);
                bits_left_d   = bits_left_q - CNT_W'(1);
                if (bits_left_w == 32'd1) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    crc_out_d     = crc_load_q;
                    verify_fail_d = (crc_rb_d != crc_load_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q       <= S_IDLE;
            buf_q         <= '0;
            buf_cnt_q     <= '0;
            bits_left_q   <= '0;
            crc_load_q    <= CRC_INIT;
            crc_rb_q      <= CRC_INIT;
            crc_out_q     <= '0;
            verify_q      <= 1'b0;
            done_q        <= 1'b0;
            verify_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            buf_cnt_q     <= buf_cnt_d;
            bits_left_q   <= bits_left_d;
            crc_load_q    <= crc_load_d;
            crc_rb_q      <= crc_rb_d;
            crc_out_q     <= crc_out_d;
            verify_q      <= verify_d;
            done_q        <= done_d;
            verify_fail_q <= verify_fail_d;
        end
    end

    assign busy        = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done        = done_q;
    assign verify_fail = verify_fail_q;
    assign crc_out     = crc_out_q;
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain flip-flops (ccff_head → … → ccff_tail shift chain).
- Accepts bitstream words from a host over a valid/ready interface and serializes them MSB-first into ccff_head. Drives a shift enable that the gated-prog_clk cell uses for the chain.
- Optionally verifies the load by recirculating the chain once (ccff_tail → ccff_head) and comparing a CRC of the read-back bits against a CRC of the loaded bits.

Parameters:
- WORD_W, 8, host word width in bits.
- CHAIN_LEN, 1024, total configuration bits in the chain; ≥1, need not be a multiple of WORD_W.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  programming clock; all state is rising-edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- verify_en  input  1  sampled with start; 1 = run VERIFY after LOAD.
- data_in  input  WORD_W  bitstream word; MSB is shifted first.
- data_valid  input  1  data_in valid.
- data_ready  output  1  loader accepts data_in this cycle.
- ccff_head  output  1  serial data into the chain.
- ccff_shift_en  output  1  chain advances on this prog_clk edge.
- ccff_tail  input  1  serial data from the chain's last stage.
- busy  output  1  state is LOAD or VERIFY.
- done  output  1  level; set on completion, cleared by the next accepted start.
- verify_fail  output  1  level; valid while done=1.
- crc_out  output  16  CRC of the loaded bits; valid while done=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE. data_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, verify_fail=0, crc_out=0. Chain content after reset is undefined; a new load is required.
- States: IDLE, LOAD, VERIFY, DONE.
  - IDLE/DONE --start--> LOAD. This clears done and verify_fail, sets bits_left=CHAIN_LEN, buf_cnt=0 and both CRCs to 16'hFFFF, and latches verify_en.
  - LOAD --last bit shifted--> VERIFY if verify_en latched, else DONE.
  - VERIFY --CHAIN_LEN shifts--> DONE.
  - start in LOAD or VERIFY is ignored.
- LOAD datapath:
  - Word buffer buf (WORD_W) with buf_cnt = valid bits remaining.
  - data_ready = LOAD && buf_cnt≤1 && bits_left>buf_cnt. This gives back-to-back words at 1 bit/cycle with no bubble.
  - Accept (valid && ready): buf←data_in, buf_cnt←min(WORD_W, bits_left−buf_cnt shifted this cycle).
  - ccff_shift_en = LOAD && buf_cnt>0. It is combinational from registered state; there is no extra latency.
  - ccff_head = buf[MSB] while shifting. On each shift: buf<<=1, buf_cnt−−, bits_left−−, and crc_load updated with the bit.
  - Host stall (buf_cnt=0, no valid): ccff_shift_en=0; the chain holds.
  - Final word with CHAIN_LEN mod WORD_W ≠0: only the upper (CHAIN_LEN mod WORD_W) bits are shifted; the remaining LSBs are discarded.
  - data_ready=0 once bits_left equals the buffered bit count. Surplus host words are never accepted.
- VERIFY:
  - ccff_shift_en=1 and ccff_head=ccff_tail every cycle for exactly CHAIN_LEN cycles; the chain content is restored.
  - The ccff_tail bit sampled each shift updates crc_rb. The first tail bit equals the first loaded bit, so the sequences align.
  - data_ready=0.
- CRC: CRC-16/CCITT, poly 0x1021, init 0xFFFF, serial, no reflection, no final XOR.
- Completion:
  - crc_out←crc_load.
  - verify_fail←(crc_rb≠crc_load) if verify was run, else 0.
  - done=1 the cycle after the last shift; busy=0 in that same cycle.
- Counters: bits_left never underflows; no wrap-around. The cycle count for LOAD is CHAIN_LEN shift cycles plus stall cycles.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, verify_en=0; words 0xA5, 0x3C, 0xF0 offered back-to-back with valid held. Required: exactly 3 accepts, exactly 20 ccff_shift_en cycles contiguous. ccff_head sequence is 10100101 00111100 1111; the 0xF0 low nibble is dropped. done=1 on cycle 21 after the first shift; crc_out = CRC16 of those 20 bits.
- Same stimulus with verify_en=1 and a 20-stage DFF chain model. Required: 20 more shift cycles with ccff_head=ccff_tail, then done=1 and verify_fail=0. The chain model holds the original pattern afterwards.
- Verify with a single chain bit forced/flipped in the model during VERIFY. Required: verify_fail=1, crc_out unchanged.
- Host stalls: drop data_valid for 5 cycles between words. Required: ccff_shift_en=0 during the stall, chain model unchanged, final content identical to the no-stall case. A fourth offered word is never accepted (data_ready stays 0).
- start pulsed mid-LOAD: ignored. Then prog_reset_n asserted mid-LOAD. Required: all outputs return to reset values asynchronously. A subsequent start performs a full, correct load.
- CHAIN_LEN=8 exact multiple: single word 0xFF. Required: exactly 8 shifts, data_ready drops after the single accept, done=1, crc_out=CRC16(0xFF, MSB-first).
